hamming74_decoder: RTL and testbench

Receive-side counterpart of the 7-bit Hamming error-injection path: accepts (possibly corrupted) Hamming(7,4) codewords, computes the syndrome, corrects any single-bit error and returns the 4 data bits. It is a 2-stage valid/ready pipeline with saturating word and error counters, so injected-error campaigns can be checked end to end on the board.

---
 rtl/hamming74_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_hamming74_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_decoder.sv
// -----------------------------------------------------------------------------
// hamming74_decoder
//
// Receive-side Hamming(7,4) decoder. Takes possibly corrupted codewords,
// computes the syndrome, corrects any single-bit error and returns the four
// data bits. Built as a 2-stage valid/ready pipeline, with saturating counters
// for delivered words and for delivered words that had a nonzero syndrome.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   d_in       received codeword, d_in[0]..d_in[6] = positions 1..7
//              (p1,p2,d1,p4,d2,d3,d4)
//   in_valid   d_in valid
//   in_ready   decoder accepts d_in this cycle
//   data_out   corrected data {d1,d2,d3,d4}
//   cw_out     corrected codeword, same ordering as d_in
//   syndrome   {s4,s2,s1} of the received word (nonzero = error position)
//   err_flag   syndrome != 0
//   out_valid  output fields valid
//   out_ready  downstream accepts the output
//   cnt_clr    synchronous clear of both counters
//   word_cnt   words delivered (output handshakes), saturating
//   err_cnt    delivered words with err_flag set, saturating
// -----------------------------------------------------------------------------
module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:6]       d_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       data_out,
    output logic [0:6]       cw_out,
    output logic [2:0]       syndrome,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // Syndrome {s4,s2,s1}; each bit is the parity of the positions whose index
    // has that bit set, so a single flip at position k yields syndrome k.
    function automatic logic [2:0] calc_syndrome(input logic [0:6] cw);
        logic s1;
        logic s2;
        logic s4;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s4, s2, s1};
    endfunction

    // Invert the position named by the syndrome; syndrome 0 passes through.
    function automatic logic [0:6] correct_cw(input logic [0:6] cw,
                                              input logic [2:0] syn);
        logic [0:6] flip;
        case (syn)
            3'd1:    flip = 7'b1000000;
            3'd2:    flip = 7'b0100000;
            3'd3:    flip = 7'b0010000;
            3'd4:    flip = 7'b0001000;
            3'd5:    flip = 7'b0000100;
            3'd6:    flip = 7'b0000010;
            3'd7:    flip = 7'b0000001;
            default: flip = 7'b0000000;
        endcase
        return cw ^ flip;
    endfunction

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 registers
    logic             v1_q,    v1_d;
    logic [0:6]       cw1_q,   cw1_d;
    logic [2:0]       syn1_q,  syn1_d;
    // Stage 2 registers (drive the outputs directly)
    logic             v2_q,    v2_d;
    logic [0:6]       cw2_q,   cw2_d;
    logic [3:0]       data2_q, data2_d;
    logic [2:0]       syn2_q,  syn2_d;
    logic             err2_q,  err2_d;
    // Statistics
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

    logic       s1_adv_s;
    logic       s2_adv_s;
    logic       in_hs_s;
    logic       out_hs_s;
    logic [0:6] cw_corr_s;

    // Flow control: a stage may advance when it is empty or its successor moves.
    always_comb begin
        s2_adv_s = !v2_q || out_ready;
        s1_adv_s = !v1_q || s2_adv_s;
        in_hs_s  = in_valid && s1_adv_s;
        out_hs_s = v2_q && out_ready;
    end

    // Next-state for both pipeline stages; data registers hold unless loaded.
    always_comb begin
        v1_d      = v1_q;
        cw1_d     = cw1_q;
        syn1_d    = syn1_q;
        v2_d      = v2_q;
        cw2_d     = cw2_q;
        data2_d   = data2_q;
        syn2_d    = syn2_q;
        err2_d    = err2_q;
        cw_corr_s = correct_cw(cw1_q, syn1_q);

        if (in_hs_s) begin
            v1_d   = 1'b1;
            cw1_d  = d_in;
            syn1_d = calc_syndrome(d_in);
        end else if (s2_adv_s) begin
            v1_d = 1'b0;
        end else begin
            v1_d = v1_q;
        end

        if (s2_adv_s) begin
            v2_d = v1_q;
            // Load only with a real word so idle outputs keep their last value.
            if (v1_q) begin
                cw2_d   = cw_corr_s;
                data2_d = {cw_corr_s[2], cw_corr_s[4], cw_corr_s[5], cw_corr_s[6]};
                syn2_d  = syn1_q;
                err2_d  = (syn1_q != 3'd0);
            end else begin
                cw2_d   = cw2_q;
                data2_d = data2_q;
                syn2_d  = syn2_q;
                err2_d  = err2_q;
            end
        end else begin
            v2_d = v2_q;
        end
    end

    // Saturating counters; a clear overrides any increment in the same cycle.
    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (cnt_clr) begin
            word_cnt_d = CNT_ZERO;
            err_cnt_d  = CNT_ZERO;
        end else if (out_hs_s) begin
            if (word_cnt_q != CNT_MAX) begin
                word_cnt_d = word_cnt_q + CNT_ONE;
            end else begin
                word_cnt_d = word_cnt_q;
            end
            if (err2_q && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            word_cnt_d = word_cnt_q;
            err_cnt_d  = err_cnt_q;
        end
    end

    // State registers with synchronous reset; reset drops in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            cw1_q      <= 7'b0000000;
            syn1_q     <= 3'd0;
            v2_q       <= 1'b0;
            cw2_q      <= 7'b0000000;
            data2_q    <= 4'd0;
            syn2_q     <= 3'd0;
            err2_q     <= 1'b0;
            word_cnt_q <= CNT_ZERO;
            err_cnt_q  <= CNT_ZERO;
        end else begin
            v1_q       <= v1_d;
            cw1_q      <= cw1_d;
            syn1_q     <= syn1_d;
            v2_q       <= v2_d;
            cw2_q      <= cw2_d;
            data2_q    <= data2_d;
            syn2_q     <= syn2_d;
            err2_q     <= err2_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = v2_q;
    assign cw_out    = cw2_q;
    assign data_out  = data2_q;
    assign syndrome  = syn2_q;
    assign err_flag  = err2_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming74_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming74_decoder
//
// Self-checking bench. The reference model treats the syndrome as the XOR of
// the indices of all set positions and keeps in-flight words in a queue;
// pipeline occupancy is the queue length. A second instance with 3-bit
// counters exercises saturation and clear.
// -----------------------------------------------------------------------------
module tb_hamming74_decoder;

    typedef struct {
        logic [0:6] cw;
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:6]  d_in = 7'b0000000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  data_out;
    logic [0:6]  cw_out;
    logic [2:0]  syndrome;
    logic        err_flag;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;

    logic [0:6]  d3_in = 7'b0000000;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [3:0]  data_out3;
    logic [0:6]  cw_out3;
    logic [2:0]  syndrome3;
    logic        err_flag3;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;
    logic        cnt_clr3 = 1'b0;
    logic [2:0]  word_cnt3;
    logic [2:0]  err_cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        q[$];
    exp_t        exp_next;
    int          wc = 0;
    int          ec = 0;
    logic        last_in_hs = 1'b0;
    logic        hold_prev = 1'b0;
    logic [0:6]  hold_cw;
    logic [3:0]  hold_data;

    hamming74_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .cw_out(cw_out),
        .syndrome(syndrome), .err_flag(err_flag), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_clr(cnt_clr), .word_cnt(word_cnt),
        .err_cnt(err_cnt)
    );

    hamming74_decoder #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .d_in(d3_in), .in_valid(in_valid3),
        .in_ready(in_ready3), .data_out(data_out3), .cw_out(cw_out3),
        .syndrome(syndrome3), .err_flag(err_flag3), .out_valid(out_valid3),
        .out_ready(out_ready3), .cnt_clr(cnt_clr3), .word_cnt(word_cnt3),
        .err_cnt(err_cnt3)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [0:6] rx);
        exp_t e;
        int   s;
        s = 0;
        for (int k = 1; k <= 7; k++) if (rx[k-1]) s = s ^ k;
        e.syn = 3'(s);
        e.err = (s != 0);
        e.cw  = rx;
        if (s != 0) e.cw[s-1] = ~e.cw[s-1];
        e.data = {e.cw[2], e.cw[4], e.cw[5], e.cw[6]};
        return e;
    endfunction

    // Place data bits, then set parity positions so the index-XOR becomes 0.
    function automatic logic [0:6] encode(input logic [3:0] d);
        logic [0:6] cw;
        int         s;
        cw    = 7'b0000000;
        cw[2] = d[3];
        cw[4] = d[2];
        cw[5] = d[1];
        cw[6] = d[0];
        s = 0;
        for (int k = 1; k <= 7; k++) if (cw[k-1]) s = s ^ k;
        cw[0] = s[0];
        cw[1] = s[1];
        cw[3] = s[2];
        return cw;
    endfunction

    // One clock: check at the negedge, update the model at the posedge.
    task automatic tick();
        logic in_hs;
        logic out_hs;
        exp_t f;
        @(negedge clk);
        check_eq("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        check_eq("word_cnt", word_cnt, wc[15:0]);
        check_eq("err_cnt", err_cnt, ec[15:0]);
        if (hold_prev) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_cw", cw_out, hold_cw);
            check_eq("hold_data", data_out, hold_data);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else begin
                f = q[0];
                check_eq("data_out", data_out, f.data);
                check_eq("cw_out", cw_out, f.cw);
                check_eq("syndrome", syndrome, f.syn);
                check_eq("err_flag", err_flag, f.err);
            end
        end
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready && (q.size() != 0);
        hold_prev = out_valid && !out_ready && !rst;
        hold_cw   = cw_out;
        hold_data = data_out;
        @(posedge clk);
        if (rst) begin
            q.delete();
            wc = 0;
            ec = 0;
            hold_prev = 1'b0;
            last_in_hs = 1'b0;
        end else begin
            if (out_hs) begin
                f = q.pop_front();
                if (wc != 65535) wc++;
                if (f.err && ec != 65535) ec++;
            end
            if (cnt_clr) begin
                wc = 0;
                ec = 0;
            end
            if (in_hs) q.push_back(exp_next);
            last_in_hs = in_hs;
        end
        #1;
    endtask

    task automatic send_model(input logic [0:6] cw);
        in_valid = 1'b1;
        d_in     = cw;
        exp_next = ref_decode(cw);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [0:6] cw;
        logic [0:6] w[5];
        int         idx;
        int         pos;
        logic       saw_stall;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_data", data_out, 4'd0);
        check_eq("rst_cw", cw_out, 7'b0000000);
        check_eq("rst_syn", syndrome, 3'd0);
        check_eq("rst_err", err_flag, 1'b0);
        check_eq("rst_wcnt", word_cnt, 16'd0);
        check_eq("rst_ecnt", err_cnt, 16'd0);
        rst = 1'b0;

        // Clean word with latency check, then single error at position 5
        send_model(7'b0110011);
        tick();
        in_valid = 1'b0;
        check_eq("lat_edge1", out_valid, 1'b0);
        tick();
        check_eq("lat_edge2", out_valid, 1'b1);
        check_eq("clean_data", data_out, 4'b1011);
        check_eq("clean_syn", syndrome, 3'd0);
        check_eq("clean_cw", cw_out, 7'b0110011);
        send_model(7'b0110111);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("clean_wcnt", word_cnt, 16'd1);
        check_eq("e5_syn", syndrome, 3'b101);
        check_eq("e5_err", err_flag, 1'b1);
        check_eq("e5_cw", cw_out, 7'b0110011);
        check_eq("e5_data", data_out, 4'b1011);
        tick();
        check_eq("e5_ecnt", err_cnt, 16'd1);
        drain();

        // Sweep 16 data values x (no error + 7 single flips), full throughput
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                cw = encode(4'(d));
                exp_next.cw   = cw;
                exp_next.data = 4'(d);
                exp_next.syn  = 3'(e);
                exp_next.err  = (e != 0);
                if (e != 0) cw[e-1] = ~cw[e-1];
                in_valid = 1'b1;
                d_in     = cw;
                tick();
                check_eq("sweep_accept", last_in_hs, 1'b1);
            end
        end
        drain();
        check_eq("sweep_wcnt", word_cnt, 16'd128);
        check_eq("sweep_ecnt", err_cnt, 16'd112);

        // Backpressure: 5 words, out_ready low for 4 cycles mid-stream
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = encode(4'($urandom_range(0, 15)));
            pos  = $urandom_range(0, 7);
            if (pos != 0) w[i][pos-1] = ~w[i][pos-1];
        end
        idx = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 40 && (idx < 5 || q.size() != 0); c++) begin
            if (idx < 5) send_model(w[idx]);
            else in_valid = 1'b0;
            out_ready = !(c >= 2 && c < 6);
            if (!in_ready) saw_stall = 1'b1;
            tick();
            if (last_in_hs) idx++;
        end
        check_eq("bp_stall_seen", saw_stall, 1'b1);
        check_eq("bp_all_sent", idx, 5);
        drain();
        check_eq("bp_wcnt", word_cnt, 16'd5);

        // Randomized traffic with 0..2 bit errors and occasional clears
        for (int cyc = 0; cyc < 400; cyc++) begin
            cw = encode(4'($urandom_range(0, 15)));
            for (int f = $urandom_range(0, 2); f > 0; f--) begin
                pos = $urandom_range(0, 6);
                cw[pos] = ~cw[pos];
            end
            send_model(cw);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) > 2);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send_model(encode(4'd5));
        tick();
        send_model(encode(4'd9));
        tick();
        in_valid = 1'b0;
        check_eq("pre_rst_full", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("post_rst_valid", out_valid, 1'b0);
        check_eq("post_rst_ready", in_ready, 1'b1);
        check_eq("post_rst_wcnt", word_cnt, 16'd0);
        check_eq("post_rst_ecnt", err_cnt, 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Saturation and clear on the 3-bit counter instance
        for (int i = 0; i < 10; i++) begin
            in_valid3 = 1'b1;
            d3_in     = 7'b0110111;
            @(posedge clk);
            #1;
        end
        in_valid3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("sat_wcnt", word_cnt3, 3'd7);
        check_eq("sat_ecnt", err_cnt3, 3'd7);
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        for (int k = 0; k < 10 && !out_valid3; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("clr_wait_valid", out_valid3, 1'b1);
        cnt_clr3 = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr3 = 1'b0;
        check_eq("clr_wcnt", word_cnt3, 3'd0);
        check_eq("clr_ecnt", err_cnt3, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
